// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with single-cycle ALU/multiply and a 32-step restoring divider.
// DIV/DIVU hold stallreq_o until the divider reaches DONE, where HI/LO are presented for one cycle.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
    localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dsr_q, dsr_d, quo_q, quo_d, rem_q, rem_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic        is_div, is_mul, sgn;
    logic [32:0] trial;
    logic [63:0] prod;
    logic [31:0] sra_res, logic_res, shift_res, arith_res;

    always_comb begin
        is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
        is_mul = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
        sgn = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_MULT_OP);
        // sign-extend to 64 bits so one 64x64 multiply serves both MULT and MULTU
        prod = {{32{sgn & reg1_i[31]}}, reg1_i} * {{32{sgn & reg2_i[31]}}, reg2_i};
        sra_res = $signed(reg2_i) >>> reg1_i[4:0];
        logic_res = aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                    aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                    aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i :
                    aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) : '0;
        shift_res = aluop_i == EXE_SLL_OP ? reg2_i << reg1_i[4:0] :
                    aluop_i == EXE_SRL_OP ? reg2_i >> reg1_i[4:0] : sra_res;
        arith_res = aluop_i == EXE_ADDU_OP ? reg1_i + reg2_i :
                    aluop_i == EXE_SUBU_OP ? reg1_i - reg2_i :
                    aluop_i == EXE_SLT_OP  ? {31'd0, $signed(reg1_i) < $signed(reg2_i)} :
                    aluop_i == EXE_SLTU_OP ? {31'd0, reg1_i < reg2_i} : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        dsr_d = dsr_q;
        quo_d = quo_q;
        rem_d = rem_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};
        case (state_q)
            IDLE: if (is_div) begin
                cnt_d = '0;
                // a zero divisor skips the iterations and loads the fixed result directly
                state_d = reg2_i == '0 ? DONE : BUSY;
                dsr_d = sgn && reg2_i[31] ? -reg2_i : reg2_i;
                quo_d = reg2_i == '0 ? '1 : sgn && reg1_i[31] ? -reg1_i : reg1_i;
                rem_d = reg2_i == '0 ? reg1_i : '0;
                qneg_d = reg2_i != '0 && sgn && (reg1_i[31] ^ reg2_i[31]);
                rneg_d = reg2_i != '0 && sgn && reg1_i[31];
            end
            BUSY: begin
                quo_d = {quo_q[30:0], ~trial[32]};
                rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
                cnt_d = cnt_q + 5'd1;
                state_d = cnt_q == 5'd31 ? DONE : BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wd_o = '0;
        wreg_o = 1'b0;
        wdata_o = '0;
        hi_o = '0;
        lo_o = '0;
        whilo_o = 1'b0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o = wd_i;
            wreg_o = wreg_i;
            wdata_o = alusel_i == EXE_RES_LOGIC ? logic_res :
                      alusel_i == EXE_RES_SHIFT ? shift_res :
                      alusel_i == EXE_RES_ARITHMETIC ? arith_res : '0;
            stallreq_o = state_q == BUSY || (state_q == IDLE && is_div);
            whilo_o = state_q == DONE || is_mul;
            {hi_o, lo_o} = state_q == DONE ? {rneg_q ? -rem_q : rem_q, qneg_q ? -quo_q : quo_q} :
                           is_mul ? prod : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against a behavioural model.
module tb_ex_stage;
    localparam logic [7:0] AND_OP   = 8'b00100100;
    localparam logic [7:0] OR_OP    = 8'b00100101;
    localparam logic [7:0] XOR_OP   = 8'b00100110;
    localparam logic [7:0] NOR_OP   = 8'b00100111;
    localparam logic [7:0] SLL_OP   = 8'b01111100;
    localparam logic [7:0] SRL_OP   = 8'b00000010;
    localparam logic [7:0] SRA_OP   = 8'b00000011;
    localparam logic [7:0] SLT_OP   = 8'b00101010;
    localparam logic [7:0] SLTU_OP  = 8'b00101011;
    localparam logic [7:0] ADDU_OP  = 8'b00100001;
    localparam logic [7:0] SUBU_OP  = 8'b00100011;
    localparam logic [7:0] MULT_OP  = 8'b00011000;
    localparam logic [7:0] MULTU_OP = 8'b00011001;
    localparam logic [7:0] DIV_OP   = 8'b00011010;
    localparam logic [7:0] DIVU_OP  = 8'b00011011;
    localparam logic [7:0] NOP_OP   = 8'b00000000;
    localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SHF = 3'b010, S_ARI = 3'b100;

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    int n_chk = 0, n_fail = 0;
    int m_busy = 0;
    bit m_done = 1'b0;
    logic [63:0] m_hilo = '0;

    logic [7:0] ops [15] = '{AND_OP, OR_OP, XOR_OP, NOR_OP, SLL_OP, SRL_OP, SRA_OP, ADDU_OP,
                             SUBU_OP, SLT_OP, SLTU_OP, MULT_OP, MULTU_OP, DIV_OP, DIVU_OP};
    logic [2:0] sels [15] = '{S_LOG, S_LOG, S_LOG, S_LOG, S_SHF, S_SHF, S_SHF, S_ARI,
                              S_ARI, S_ARI, S_ARI, S_NOP, S_NOP, S_NOP, S_NOP};

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit is_div(input logic [7:0] op);
        return op == DIV_OP || op == DIVU_OP;
    endfunction

    function automatic bit is_mul(input logic [7:0] op);
        return op == MULT_OP || op == MULTU_OP;
    endfunction

    function automatic logic [31:0] gpr(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int sb;
        sb = int'(b);
        case (op)
            AND_OP:  return a & b;
            OR_OP:   return a | b;
            XOR_OP:  return a ^ b;
            NOR_OP:  return ~(a | b);
            SLL_OP:  return b << a[4:0];
            SRL_OP:  return b >> a[4:0];
            SRA_OP:  return 32'(sb >>> a[4:0]);
            ADDU_OP: return a + b;
            SUBU_OP: return a - b;
            SLT_OP:  return int'(a) < int'(b) ? 32'd1 : 32'd0;
            SLTU_OP: return a < b ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(int'(a)) * longint'(int'(b));
        return op == MULT_OP ? 64'(p) : 64'(a) * 64'(b);
    endfunction

    // returns {hi, lo}
    function automatic logic [63:0] div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (op == DIVU_OP) return {a % b, a / b};
        q = longint'(int'(a)) / longint'(int'(b));
        r = longint'(int'(a)) % longint'(int'(b));
        return {r[31:0], q[31:0]};
    endfunction

    // divider model: cycles remaining in the busy phase, then one result cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) m_done <= 1'b1;
        end else if (is_div(aluop_i)) begin
            m_hilo <= div(aluop_i, reg1_i, reg2_i);
            if (reg2_i == 0) m_done <= 1'b1;
            else m_busy <= 32;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {wd_o, wreg_o, whilo_o, stallreq_o}, 64'd0);
            chk("rst_data", {wdata_o, hi_o | lo_o}, 64'd0);
        end else begin
            chk("wd", {wd_o, wreg_o}, {wd_i, wreg_i});
            chk("wdata", wdata_o, alusel_i == S_NOP ? 32'd0 : gpr(aluop_i, reg1_i, reg2_i));
            chk("stall", stallreq_o, !m_done && (m_busy > 0 || is_div(aluop_i)));
            chk("whilo", whilo_o, m_done || is_mul(aluop_i));
            chk("hilo", {hi_o, lo_o}, m_done ? m_hilo : is_mul(aluop_i) ? mul(aluop_i, reg1_i, reg2_i) : 64'd0);
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr);
        aluop_i = op;
        alusel_i = sel;
        reg1_i = a;
        reg2_i = b;
        wd_i = wd;
        wreg_i = wr;
        #1;
    endtask

    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_hilo, input int exp_stall);
        int cnt;
        drive(op, S_NOP, a, b, 5'd0, 1'b0);
        cnt = 0;
        while (stallreq_o && cnt < 100) begin
            cnt++;
            next_cycle();
        end
        chk({name, "_stall_len"}, 64'(cnt), 64'(exp_stall));
        chk({name, "_hilo"}, {hi_o, lo_o}, exp_hilo);
        chk({name, "_whilo"}, whilo_o, 1'b1);
        next_cycle();
        drive(NOP_OP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        chk({name, "_idle"}, {whilo_o, stallreq_o}, 2'b00);
        next_cycle();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, k;
        drive(ADDU_OP, S_ARI, 32'd1, 32'd2, 5'd7, 1'b1);
        chk("reset_state", {wd_o, wreg_o, whilo_o, stallreq_o, wdata_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(ADDU_OP, S_ARI, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
        chk("addu_wdata", wdata_o, 32'h80000000);
        chk("addu_wd", {wd_o, wreg_o, whilo_o}, {5'd5, 1'b1, 1'b0});
        next_cycle();
        drive(SRA_OP, S_SHF, 32'd4, 32'h80000000, 5'd3, 1'b1);
        chk("sra", wdata_o, 32'hF8000000);
        next_cycle();
        drive(SLT_OP, S_ARI, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
        chk("slt", wdata_o, 32'd1);
        next_cycle();
        drive(SLTU_OP, S_ARI, 32'hFFFFFFFF, 32'd1, 5'd3, 1'b1);
        chk("sltu", wdata_o, 32'd0);
        next_cycle();
        drive(MULT_OP, S_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
        chk("mult_whilo", whilo_o, 1'b1);
        next_cycle();
        run_div("div_m7_2", DIV_OP, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("divu_by0", DIVU_OP, 32'd10, 32'd0, 64'h0000000A_FFFFFFFF, 1);
        run_div("div_ovf", DIV_OP, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

        // abort a division mid-flight with an asynchronous reset
        drive(DIVU_OP, S_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
        repeat (11) next_cycle();
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", {whilo_o, stallreq_o, wd_o, wreg_o}, 64'd0);
        chk("abort_data", {hi_o, lo_o}, 64'd0);
        next_cycle();
        drive(NOP_OP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("abort_no_whilo", {whilo_o, stallreq_o}, 2'b00);
            next_cycle();
        end
        run_div("divu_100_7", DIVU_OP, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 14);
            drive(ops[k], sels[k], rnd32(), rnd32(), 5'($urandom), 1'($urandom));
            cnt = 0;
            while (stallreq_o && cnt < 40) begin
                cnt++;
                next_cycle();
            end
            chk("rand_stall_len", 64'(cnt), is_div(ops[k]) ? (reg2_i == 0 ? 64'd1 : 64'd33) : 64'd0);
            next_cycle();
        end
        drive(NOP_OP, S_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
